// File: rtl/imem_program_loader_if.sv
// Signal bundle between a byte-stream host and the program loader.
// Carries the host byte link, the imem write port and the core-reset/status outputs.
interface imem_program_loader_if #(
    parameter int ADDR_WIDTH = 8
);
    logic                  start;
    logic                  in_valid;
    logic [7:0]            in_data;
    logic                  in_ready;
    logic                  imem_we;
    logic [ADDR_WIDTH-1:0] imem_addr;
    logic [31:0]           imem_wdata;
    logic                  cpu_rst;
    logic                  done;
    logic                  error;
    logic [ADDR_WIDTH:0]   words_loaded;

    modport master (
        output start, in_valid, in_data,
        input  in_ready, imem_we, imem_addr, imem_wdata, cpu_rst, done, error, words_loaded
    );

    modport slave (
        input  start, in_valid, in_data,
        output in_ready, imem_we, imem_addr, imem_wdata, cpu_rst, done, error, words_loaded
    );
endinterface

// File: rtl/imem_program_loader.sv
// Loads a framed, XOR-checksummed byte stream into imem as little-endian words.
// Holds the core in reset until the image is complete and its checksum matches.
module imem_program_loader #(
    parameter int          ADDR_WIDTH = 8,
    parameter int unsigned BASE_ADDR  = 0,
    parameter int unsigned RESET_HOLD = 4
) (
    input logic                  clk,
    input logic                  rst,
    imem_program_loader_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_LEN0, S_LEN1, S_DATA, S_CSUM, S_RELEASE, S_RUN, S_ERROR
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] BASE      = ADDR_WIDTH'(BASE_ADDR);
    localparam logic [16:0]           MAX_WORDS = 17'(2 ** ADDR_WIDTH);
    localparam logic [7:0]            HOLD_LAST = 8'(RESET_HOLD - 1);
    localparam logic [ADDR_WIDTH:0]   WORD_ONE  = (ADDR_WIDTH + 1)'(1);

    state_t                state, state_next;
    logic                  ready, byte_in, accept, word_done;
    logic [7:0]            acc, len_lo, hold_cnt;
    logic [16:0]           len_full;
    logic [ADDR_WIDTH:0]   word_total, word_cnt, words_q;
    logic [1:0]            byte_idx;
    logic [23:0]           word_buf;
    logic                  we_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [31:0]           wdata_q;

    // A byte offered together with start is never taken: start wins.
    assign byte_in  = bus.in_valid & ~bus.start;
    assign accept   = ready & bus.in_valid;
    assign len_full = {1'b0, bus.in_data, len_lo};

    always_comb begin
        // NOTE: defaults first so no path through the case leaves a signal unassigned (no latch).
        state_next = state;
        ready      = 1'b0;
        word_done  = 1'b0;
        case (state)
            S_LEN0: begin
                ready = ~bus.start;
                if (byte_in) state_next = S_LEN1;
            end
            S_LEN1: begin
                ready = ~bus.start;
                if (byte_in) begin
                    if (len_full > MAX_WORDS)  state_next = S_ERROR;
                    else if (len_full == '0)   state_next = S_CSUM;
                    else                       state_next = S_DATA;
                end
            end
            S_DATA: begin
                ready = ~bus.start;
                if (byte_in && byte_idx == 2'd3) begin
                    word_done = 1'b1;
                    if (word_cnt + WORD_ONE == word_total) state_next = S_CSUM;
                end
            end
            S_CSUM: begin
                ready = ~bus.start;
                if (byte_in) state_next = (bus.in_data == acc) ? S_RELEASE : S_ERROR;
            end
            S_RELEASE: begin
                if (hold_cnt == HOLD_LAST) state_next = S_RUN;
            end
            default: ;
        endcase
        if (bus.start) state_next = S_LEN0;
    end

    // NOTE: sequential state uses <= so every flop samples pre-edge values regardless of block order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc        <= '0;
            len_lo     <= '0;
            hold_cnt   <= '0;
            word_total <= '0;
            word_cnt   <= '0;
            words_q    <= '0;
            byte_idx   <= '0;
            word_buf   <= '0;
            we_q       <= 1'b0;
            addr_q     <= BASE;
            wdata_q    <= '0;
        end else begin
            we_q <= word_done;
            if (word_done) begin
                addr_q  <= BASE + word_cnt[ADDR_WIDTH-1:0];
                wdata_q <= {bus.in_data, word_buf};
                words_q <= words_q + WORD_ONE;
            end
            // A restart drops the partial word; a write issued last cycle has already left.
            if (bus.start) begin
                acc      <= '0;
                hold_cnt <= '0;
                word_cnt <= '0;
                words_q  <= '0;
                byte_idx <= '0;
                word_buf <= '0;
            end else begin
                if (accept) acc <= acc ^ bus.in_data;
                case (state)
                    S_LEN0: if (accept) len_lo <= bus.in_data;
                    S_LEN1: if (accept) word_total <= len_full[ADDR_WIDTH:0];
                    S_DATA: begin
                        if (accept) begin
                            byte_idx <= byte_idx + 2'd1;
                            case (byte_idx)
                                2'd0:    word_buf[7:0]   <= bus.in_data;
                                2'd1:    word_buf[15:8]  <= bus.in_data;
                                2'd2:    word_buf[23:16] <= bus.in_data;
                                default: word_cnt        <= word_cnt + WORD_ONE;
                            endcase
                        end
                    end
                    S_RELEASE: hold_cnt <= hold_cnt + 8'd1;
                    default: ;
                endcase
            end
        end
    end

    assign bus.in_ready     = ready;
    assign bus.imem_we      = we_q;
    assign bus.imem_addr    = addr_q;
    assign bus.imem_wdata   = wdata_q;
    assign bus.words_loaded = words_q;
    assign bus.cpu_rst      = (state != S_RUN);
    assign bus.done         = (state == S_RUN);
    assign bus.error        = (state == S_ERROR);
endmodule

// File: tb/tb_imem_program_loader.sv
// Self-checking bench for imem_program_loader: frames built from random words,
// expected writes/checksums/timing derived from the framing rules.
module tb_imem_program_loader;
    localparam int AW   = 8;
    localparam int HOLD = 4;
    localparam int BASE = 0;

    typedef logic [31:0] word_q_t[$];

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int          checks = 0;
    int          errors = 0;
    int unsigned cyc = 0;

    logic [AW-1:0] wq_addr[$];
    logic [31:0]   wq_data[$];
    int unsigned   wq_cyc[$];

    imem_program_loader_if #(.ADDR_WIDTH(AW)) bus ();

    imem_program_loader #(
        .ADDR_WIDTH(AW),
        .BASE_ADDR (BASE),
        .RESET_HOLD(HOLD)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Write monitor: one entry per cycle with imem_we high.
    always @(negedge clk) begin
        if (bus.imem_we === 1'b1) begin
            wq_addr.push_back(bus.imem_addr);
            wq_data.push_back(bus.imem_wdata);
            wq_cyc.push_back(cyc);
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic word_q_t rand_words(input int n);
        word_q_t q;
        for (int i = 0; i < n; i++) q.push_back($urandom);
        return q;
    endfunction

    function automatic int model_addr(input int idx);
        return (BASE + idx) % (2 ** AW);
    endfunction

    task automatic clear_writes();
        wq_addr.delete();
        wq_data.delete();
        wq_cyc.delete();
    endtask

    // Offers one byte after a random idle gap; returns the cycle number of the accepting edge.
    task automatic send_byte(input logic [7:0] b, input int max_gap, output int unsigned acc_cyc);
        int gap;
        bit ok;
        ok      = 1'b0;
        acc_cyc = 0;
        gap     = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
        repeat (gap) begin
            @(negedge clk);
            bus.in_valid = 1'b0;
            bus.in_data  = 8'($urandom);
        end
        for (int t = 0; t < 64 && !ok; t++) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.in_data  = b;
            #1;
            if (bus.in_ready === 1'b1) begin
                @(posedge clk);
                #1;
                acc_cyc      = cyc;
                bus.in_valid = 1'b0;
                ok           = 1'b1;
            end
        end
        bus.in_valid = 1'b0;
        check("byte_accepted", ok, 1'b1);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
    endtask

    // Sends a complete frame for the given words and checks writes, count and release/error.
    task automatic load_frame(input word_q_t words, input bit bad_csum, input int max_gap,
                              input bit do_start, input bit finish);
        int          n;
        logic [15:0] len;
        logic [7:0]  cs;
        logic [31:0] w;
        int unsigned acc_c;
        int unsigned word_c[$];
        n   = words.size();
        len = 16'(n);
        if (do_start) pulse_start();
        clear_writes();
        cs = len[7:0] ^ len[15:8];
        send_byte(len[7:0], max_gap, acc_c);
        send_byte(len[15:8], max_gap, acc_c);
        for (int i = 0; i < n; i++) begin
            w = words[i];
            for (int k = 0; k < 4; k++) begin
                send_byte(w[8*k +: 8], max_gap, acc_c);
                cs = cs ^ w[8*k +: 8];
            end
            word_c.push_back(acc_c);
        end
        if (bad_csum) cs = cs ^ 8'h01;
        send_byte(cs, max_gap, acc_c);
        @(negedge clk);
        check("write_count", wq_addr.size(), n);
        for (int i = 0; i < n && i < wq_addr.size(); i++) begin
            check($sformatf("write_addr[%0d]", i), wq_addr[i], model_addr(i));
            check($sformatf("write_data[%0d]", i), wq_data[i], words[i]);
            check($sformatf("write_cycle[%0d]", i), wq_cyc[i], word_c[i]);
        end
        check("words_loaded", bus.words_loaded, n);
        if (finish) begin
            if (bad_csum) begin
                for (int i = 0; i < 4; i++) begin
                    if (i > 0) @(negedge clk);
                    check("error_flag", bus.error, 1'b1);
                    check("error_cpu_rst", bus.cpu_rst, 1'b1);
                    check("error_done", bus.done, 1'b0);
                end
                check("error_in_ready", bus.in_ready, 1'b0);
            end else begin
                for (int i = 0; i < HOLD; i++) begin
                    if (i > 0) @(negedge clk);
                    check($sformatf("hold_cpu_rst[%0d]", i), bus.cpu_rst, 1'b1);
                    check($sformatf("hold_done[%0d]", i), bus.done, 1'b0);
                end
                @(negedge clk);
                check("run_cpu_rst", bus.cpu_rst, 1'b0);
                check("run_done", bus.done, 1'b1);
                check("run_error", bus.error, 1'b0);
                check("run_in_ready", bus.in_ready, 1'b0);
            end
        end
    endtask

    initial begin
        word_q_t     wq;
        logic [31:0] p;
        int unsigned acc_c;

        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        rst          = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_cpu_rst", bus.cpu_rst, 1'b1);
        check("rst_in_ready", bus.in_ready, 1'b0);
        check("rst_imem_we", bus.imem_we, 1'b0);
        check("rst_done", bus.done, 1'b0);
        check("rst_error", bus.error, 1'b0);
        check("rst_imem_addr", bus.imem_addr, BASE);
        check("rst_imem_wdata", bus.imem_wdata, 32'h0);
        check("rst_words_loaded", bus.words_loaded, 0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_in_ready", bus.in_ready, 1'b0);
        check("idle_cpu_rst", bus.cpu_rst, 1'b1);

        // Single-word image, then RUN persists.
        wq = {32'h00500013};
        load_frame(wq, 1'b0, 0, 1'b1, 1'b1);
        repeat (5) @(negedge clk);
        check("run_persists_done", bus.done, 1'b1);
        check("run_persists_cpu_rst", bus.cpu_rst, 1'b0);

        // Three words with random valid gaps, then a few random-length images.
        load_frame(rand_words(3), 1'b0, 3, 1'b1, 1'b1);
        for (int r = 0; r < 4; r++) load_frame(rand_words(1 + int'($urandom_range(4, 0))), 1'b0, 2, 1'b1, 1'b1);

        // Checksum off by one bit, then recovery with a good frame.
        wq = {32'h00500013};
        load_frame(wq, 1'b1, 0, 1'b1, 1'b1);
        load_frame(rand_words(2), 1'b0, 1, 1'b1, 1'b1);

        // Empty image and largest image.
        load_frame(rand_words(0), 1'b0, 0, 1'b1, 1'b1);
        load_frame(rand_words(2 ** AW), 1'b0, 0, 1'b1, 1'b1);

        // Oversized length: N = 2**AW + 1.
        pulse_start();
        clear_writes();
        send_byte(8'h01, 0, acc_c);
        send_byte(8'h01, 0, acc_c);
        @(negedge clk);
        check("oversize_error", bus.error, 1'b1);
        check("oversize_in_ready", bus.in_ready, 1'b0);
        check("oversize_cpu_rst", bus.cpu_rst, 1'b1);
        repeat (4) @(negedge clk);
        check("oversize_no_write", wq_addr.size(), 0);
        check("oversize_error_held", bus.error, 1'b1);

        // Restart after 6 payload bytes of a 2-word load; concurrent byte must be refused.
        pulse_start();
        clear_writes();
        send_byte(8'h02, 1, acc_c);
        send_byte(8'h00, 1, acc_c);
        p = $urandom;
        for (int k = 0; k < 4; k++) send_byte(p[8*k +: 8], 1, acc_c);
        p = $urandom;
        for (int k = 0; k < 2; k++) send_byte(p[8*k +: 8], 1, acc_c);
        @(negedge clk);
        bus.start    = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h5A;
        #1 check("start_masks_ready", bus.in_ready, 1'b0);
        @(posedge clk);
        #1;
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("restart_words_loaded", bus.words_loaded, 0);
        check("restart_in_ready", bus.in_ready, 1'b1);
        check("restart_cpu_rst", bus.cpu_rst, 1'b1);
        check("restart_error", bus.error, 1'b0);
        check("restart_only_word0", wq_addr.size(), 1);
        load_frame(rand_words(1), 1'b0, 1, 1'b0, 1'b1);

        // Start in the cycle a write is pending: the write still goes out.
        pulse_start();
        clear_writes();
        send_byte(8'h02, 0, acc_c);
        send_byte(8'h00, 0, acc_c);
        p = $urandom;
        for (int k = 0; k < 4; k++) send_byte(p[8*k +: 8], 0, acc_c);
        @(negedge clk);
        bus.start = 1'b1;
        #1;
        check("pending_we", bus.imem_we, 1'b1);
        check("pending_addr", bus.imem_addr, model_addr(0));
        check("pending_wdata", bus.imem_wdata, p);
        @(posedge clk);
        #1 bus.start = 1'b0;
        @(negedge clk);
        check("after_pending_we", bus.imem_we, 1'b0);
        check("after_pending_words", bus.words_loaded, 0);

        // Asynchronous reset during the release hold.
        load_frame(rand_words(1), 1'b0, 0, 1'b1, 1'b0);
        @(negedge clk);
        check("release_cpu_rst", bus.cpu_rst, 1'b1);
        rst = 1'b1;
        #1;
        check("arst_cpu_rst", bus.cpu_rst, 1'b1);
        check("arst_done", bus.done, 1'b0);
        check("arst_in_ready", bus.in_ready, 1'b0);
        check("arst_words_loaded", bus.words_loaded, 0);
        check("arst_imem_we", bus.imem_we, 1'b0);
        repeat (HOLD + 2) @(negedge clk);
        rst = 1'b0;
        repeat (HOLD + 2) @(negedge clk);
        check("post_rst_done", bus.done, 1'b0);
        check("post_rst_cpu_rst", bus.cpu_rst, 1'b1);
        check("post_rst_in_ready", bus.in_ready, 1'b0);
        load_frame(rand_words(2), 1'b0, 2, 1'b1, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
